// File: rtl/m68k_bus_pkg.sv
// Shared 68000 bus definitions: cycle-controller states, decoded regions and
// the default wait-state counts also used by the address decoder.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    BERR = 2'd3
  } busState_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    ROM  = 3'd1,
    RAM  = 3'd2,
    IO   = 3'd3,
    CAN  = 3'd4,
    DRAM = 3'd5
  } busRegion_t;

  localparam int DEFAULT_ROM_WAIT       = 1;
  localparam int DEFAULT_RAM_WAIT       = 0;
  localparam int DEFAULT_IO_WAIT        = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Regions whose acknowledge comes from a local wait-state count rather than
  // from an external controller.
  function automatic logic isFixedRegion(input busRegion_t region);
    return (region == ROM) || (region == RAM) || (region == IO);
  endfunction

endpackage

// File: rtl/bus_timeout_timer.sv
// 8-bit saturating cycle timer. termCount is high when the next enabled edge
// brings the count up to LIMIT, so the owner can act on that same edge.
module bus_timeout_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic termCount
);

  logic [7:0] count;

  // Count enabled edges; clear wins over enable and the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign termCount = (count >= 8'(LIMIT - 1));

endmodule

// File: rtl/dtack_generator.sv
// 68000 bus-cycle controller: per-region DTACK_L generation with fixed wait
// states or external handshakes, and a bus-error timeout with a sticky flag.
//
// state | meaning
// IDLE  | no bus cycle in progress, watching for AS_L plus a data strobe
// WAIT  | cycle started, counting wait states or waiting for a handshake
// ACK   | DTACK_L asserted until the CPU releases AS_L
// BERR  | BERR_L asserted until the CPU releases AS_L
module dtack_generator
  import m68k_bus_pkg::*;
#(
  parameter int ROM_WAIT       = DEFAULT_ROM_WAIT,
  parameter int RAM_WAIT       = DEFAULT_RAM_WAIT,
  parameter int IO_WAIT        = DEFAULT_IO_WAIT,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic Clk,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramSelect_H,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  input  logic ClearTimeout_H,
  output logic DTACK_L,
  output logic BERR_L,
  output logic BusTimeout_H
);

  localparam logic [3:0] ROM_WAIT_CNT = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_CNT = 4'(RAM_WAIT);
  localparam logic [3:0] IO_WAIT_CNT  = 4'(IO_WAIT);

  busState_t  state, nextState;
  busRegion_t region, nextRegion;
  busRegion_t selRegion;
  logic [3:0] waitCnt, nextWaitCnt;
  logic [3:0] selWait;
  logic       cycleStart;
  logic       timerClear;
  logic       timerEnable;
  logic       timerTc;

  assign cycleStart = !AS_L && (!UDS_L || !LDS_L);

  // Decode the live selects by priority; only sampled at cycle start.
  always_comb begin
    selRegion = NONE;
    selWait   = 4'd0;
    if (OnChipRomSelect_H) begin
      selRegion = ROM;
      selWait   = ROM_WAIT_CNT;
    end else if (OnChipRamSelect_H) begin
      selRegion = RAM;
      selWait   = RAM_WAIT_CNT;
    end else if (IOSelect_H) begin
      selRegion = IO;
      selWait   = IO_WAIT_CNT;
    end else if (CanBusSelect_H) begin
      selRegion = CAN;
    end else if (DramSelect_H) begin
      selRegion = DRAM;
    end
  end

  bus_timeout_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimer (
    .clk      (Clk),
    .rst      (Reset_H),
    .clear    (timerClear),
    .enable   (timerEnable),
    .termCount(timerTc)
  );

  // Next-state logic; in WAIT an abort beats a timeout, which beats an ack.
  always_comb begin
    nextState   = state;
    nextRegion  = region;
    nextWaitCnt = waitCnt;
    timerClear  = 1'b0;
    timerEnable = 1'b0;
    case (state)
      IDLE: begin
        if (cycleStart) begin
          nextRegion  = selRegion;
          timerClear  = 1'b1;
          nextWaitCnt = selWait;
          if (isFixedRegion(selRegion) && (selWait == 4'd0)) begin
            nextState = ACK;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        timerEnable = 1'b1;
        if (AS_L) begin
          nextState = IDLE;
        end else if (timerTc) begin
          nextState = BERR;
        end else begin
          case (region)
            ROM, RAM, IO: begin
              if (waitCnt == 4'd1) begin
                nextState = ACK;
              end else begin
                nextWaitCnt = waitCnt - 4'd1;
              end
            end
            CAN: begin
              if (!CanBusDtack_L) nextState = ACK;
            end
            DRAM: begin
              if (!DramDtack_L) nextState = ACK;
            end
            default: begin
              nextState = WAIT;
            end
          endcase
        end
      end
      ACK, BERR: begin
        if (AS_L) nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State, captured region and wait count registers.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      state   <= IDLE;
      region  <= NONE;
      waitCnt <= 4'd0;
    end else begin
      state   <= nextState;
      region  <= nextRegion;
      waitCnt <= nextWaitCnt;
    end
  end

  // Strobes registered from the next state so they track the state register exactly.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      DTACK_L <= 1'b1;
      BERR_L  <= 1'b1;
    end else begin
      DTACK_L <= !(nextState == ACK);
      BERR_L  <= !(nextState == BERR);
    end
  end

  // Sticky timeout flag for the debugger; a new bus error beats a clear.
  always_ff @(posedge Clk or posedge Reset_H) begin
    if (Reset_H) begin
      BusTimeout_H <= 1'b0;
    end else if ((nextState == BERR) && (state != BERR)) begin
      BusTimeout_H <= 1'b1;
    end else if (ClearTimeout_H) begin
      BusTimeout_H <= 1'b0;
    end
  end

endmodule
